fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Generates the instruction fetch address (`addr_t`) presented to the 64-byte program memory each cycle. Holds the 4-bit program counter, the current execution mode (normal, software interrupt, exception, hardware interrupt), and the saved return context. Sits directly upstream of `memory`; takes control requests from the decode/execute stage.

## Interface
Parameters:
- `HWI_LEVEL`, default 0: 0 means the hardware interrupt request is edge-captured into a pending latch; 1 means it is level-sampled with no latch.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `step`  input  1  instruction-advance enable; no state changes when 0.
- `jump`  input  1  taken jump in the current instruction.
- `jump_target`  input  4  PC target for `jump`.
- `swi`  input  1  software interrupt instruction executing.
- `iret`  input  1  return-from-handler instruction executing.
- `exc`  input  1  exception raised by the current instruction.
- `hwi_req`  input  1  external hardware interrupt request.
- `addr`  output  `addr_t`  fetch address; `addr.phys_addr` = {mode[1:0], pc[3:0]}.
- `mode`  output  `mode_e`  current execution mode.
- `hwi_ack`  output  1  one-cycle pulse on the step that enters HWI mode.
- `double_fault`  output  1  sticky flag: exception raised while already in a handler.

## Operation
- Mode encoding, which is also the phys_addr upper bits: NORMAL=0, SWI=1, EXC=2, HWI=3. Each handler occupies a 16-byte region starting at PC 0.
- Registers: `pc`[3:0], `mode`, `ret_pc`[3:0], `hwi_pending`, `double_fault`.
- On each `step`=1 edge, evaluate in this priority order:
  1. `exc`, or `iret` in NORMAL mode:
     - mode→EXC, pc→0.
     - From NORMAL: ret_pc←pc, so the faulting instruction is retried.
     - From a handler: ret_pc unchanged, double_fault←1.
  2. Effective HWI request in NORMAL mode: mode→HWI, pc→0, ret_pc←next_pc, hwi_ack=1, hwi_pending←0.
     - next_pc is `jump_target` if `jump`, else pc+1.
     - The current instruction completes.
  3. `swi` in NORMAL mode: mode→SWI, pc→0, ret_pc←pc+1 (mod 16).
  4. `iret` in a handler: mode→NORMAL, pc←ret_pc.
  5. `jump`: pc←jump_target.
  6. Otherwise: pc←pc+1. Wraps 15→0 within the same mode region; mode is unchanged.
- Effective HWI request:
  - `HWI_LEVEL`=0: `hwi_pending` is set on a rising edge of `hwi_req`, sampled every clock regardless of `step`. The request is `hwi_pending`.
  - `HWI_LEVEL`=1: the request is `hwi_req` itself.
- No nesting:
  - `swi` inside a handler is ignored and treated as a plain increment.
  - HWI arriving in a handler stays pending and is taken on the first NORMAL-mode step after `iret`.
- `double_fault` clears only on `rst`.

## Timing
- `addr`, `mode`, and `double_fault` are driven directly from registers. `memory` is combinational, so the instruction for `addr` is valid in the same cycle; there is zero added latency.
- Redirects (jump, interrupt entry, `iret`) take effect on the edge where `step`=1. The new address appears the following cycle.
- `hwi_ack` is combinational from the step-edge decision: asserted in the cycle before the edge that enters HWI.
- Simultaneous events resolve strictly by the priority list above. Example: `exc`+`swi` → EXC only.
- Reset values: pc=0, mode=NORMAL, ret_pc=0, hwi_pending=0, double_fault=0, hwi_ack=0, addr.phys_addr=0.
- Reset asserted mid-handler discards all context. A `hwi_req` edge in the reset cycle is not captured.

## Structure
- Add to the shared package (`types.svh`):
  - `mode_e` (2-bit enum).
  - `PC_W`=4.
  - Helper function `make_addr(mode, pc)`.
- `addr_t` stays as already defined there.
- One natural sub-module: `hwi_pending_latch`, which performs edge detection plus the pending flag, with clear on ack and clear on reset.
- Everything else is a single `always_ff` for state plus an `always_comb` for next-state decode.

## Test plan
- Reset, then 16 steps with no controls → phys_addr 0..15, then wraps to 0. Mode stays NORMAL.
- At pc=5, `swi` → phys_addr 0x10. Next three steps → 0x11..0x13. Then `iret` → phys_addr 6, mode NORMAL.
- At pc=3, raise `exc` → phys_addr 0x20. During the handler raise `exc` again → pc 0x20, double_fault=1. `iret` returns to pc 3.
- `hwi_req` pulsed while in the SWI handler → no entry. After `iret`, the first step yields phys_addr 0x30 with a one-cycle `hwi_ack`.
- At pc=7, `jump`=1 with `jump_target`=2, `exc`=1, and `hwi_req` pending, all on the same step → EXC wins, ret_pc=7. Then the HWI is taken after `iret`.
- `step`=0 for 10 cycles with `jump` asserted → phys_addr unchanged. `rst` in HWI mode → phys_addr 0, all flags 0.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared types for the fetch sequencer and its neighbours.
//   mode_e    : execution mode; its encoding doubles as the upper fetch-address bits
//   addr_t    : fetch address presented to the 64-byte program memory
//   make_addr : builds an addr_t from mode and pc
package fetch_sequencer_pkg;

    localparam int PC_W   = 4;
    localparam int MODE_W = 2;
    localparam int PHYS_W = MODE_W + PC_W;

    typedef enum logic [MODE_W-1:0] {
        MODE_NORMAL = 2'd0,
        MODE_SWI    = 2'd1,
        MODE_EXC    = 2'd2,
        MODE_HWI    = 2'd3
    } mode_e;

    typedef struct packed {
        logic [PHYS_W-1:0] phys_addr;
    } addr_t;

    // Each mode owns a 16-byte region, so the mode selects the region.
    function automatic addr_t make_addr(input mode_e m, input logic [PC_W-1:0] pc);
        addr_t a;
        a.phys_addr = {m, pc};
        return a;
    endfunction

endpackage

// File: rtl/fetch_sequencer_hwi.sv
// Hardware-interrupt pending latch: rising-edge detect on req plus a sticky
// pending flag that is cleared when the interrupt is accepted.
//   clk, rst : clock, synchronous active-high reset
//   req      : raw interrupt request, sampled every clock
//   clr      : acceptance pulse (clears pending on this edge)
//   pending  : registered pending flag
module hwi_pending_latch (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic clr,
    output logic pending
);

    logic req_d;
    logic rise;

    assign rise = req & ~req_d;

    always_ff @(posedge clk) begin
        // req_d keeps tracking during reset so an edge inside the reset
        // cycle is consumed rather than seen afterwards.
        req_d <= req;
        if (rst)
            pending <= 1'b0;
        else if (rise)
            pending <= 1'b1;   // a fresh edge beats a simultaneous ack
        else if (clr)
            pending <= 1'b0;
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch address sequencer: program counter, execution mode,
// return context and double-fault tracking.
//   clk, rst          : clock, synchronous active-high reset
//   step              : advance enable; nothing changes while low
//   jump, jump_target : taken jump and its pc target
//   swi, iret, exc    : software interrupt, handler return, exception
//   hwi_req           : external hardware interrupt request
//   addr              : fetch address {mode, pc}
//   mode              : current execution mode
//   hwi_ack           : high in the cycle whose step edge enters HWI mode
//   double_fault      : sticky, exception raised while in a handler
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int HWI_LEVEL = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            step,
    input  logic            jump,
    input  logic [PC_W-1:0] jump_target,
    input  logic            swi,
    input  logic            iret,
    input  logic            exc,
    input  logic            hwi_req,
    output addr_t           addr,
    output mode_e           mode,
    output logic            hwi_ack,
    output logic            double_fault
);

    logic [PC_W-1:0] pc, pc_nxt;
    logic [PC_W-1:0] ret_pc, ret_pc_nxt;
    mode_e           mode_nxt;
    logic            df_nxt;
    logic            hwi_eff;
    logic            take_hwi;

    if (HWI_LEVEL == 0) begin : g_edge
        logic hwi_pending;
        hwi_pending_latch u_latch (
            .clk     (clk),
            .rst     (rst),
            .req     (hwi_req),
            .clr     (take_hwi),
            .pending (hwi_pending)
        );
        assign hwi_eff = hwi_pending;
    end else begin : g_level
        assign hwi_eff = hwi_req;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            pc           <= '0;
            mode         <= MODE_NORMAL;
            ret_pc       <= '0;
            double_fault <= 1'b0;
        end else begin
            pc           <= pc_nxt;
            mode         <= mode_nxt;
            ret_pc       <= ret_pc_nxt;
            double_fault <= df_nxt;
        end
    end

    // Next-state decode, strict priority
    always_comb begin
        logic in_normal;
        logic [PC_W-1:0] seq_pc;
        in_normal  = (mode == MODE_NORMAL);
        seq_pc     = jump ? jump_target : pc + PC_W'(1);
        pc_nxt     = pc;
        mode_nxt   = mode;
        ret_pc_nxt = ret_pc;
        df_nxt     = double_fault;
        take_hwi   = 1'b0;
        if (step) begin
            if (exc || (iret && in_normal)) begin
                mode_nxt = MODE_EXC;
                pc_nxt   = '0;
                if (in_normal)
                    ret_pc_nxt = pc;   // retry the faulting instruction
                else
                    df_nxt = 1'b1;
            end else if (hwi_eff && in_normal) begin
                // Current instruction completes; resume after it.
                take_hwi   = 1'b1;
                mode_nxt   = MODE_HWI;
                pc_nxt     = '0;
                ret_pc_nxt = seq_pc;
            end else if (swi && in_normal) begin
                mode_nxt   = MODE_SWI;
                pc_nxt     = '0;
                ret_pc_nxt = pc + PC_W'(1);
            end else if (iret) begin
                mode_nxt = MODE_NORMAL;
                pc_nxt   = ret_pc;
            end else begin
                pc_nxt = seq_pc;   // swi in a handler lands here too
            end
        end
    end

    // Outputs
    always_comb begin
        addr    = make_addr(mode, pc);
        hwi_ack = take_hwi;
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       rst, step, jump, swi, iret, exc, hwi_req;
    logic [3:0] jump_target;
    addr_t      addr;
    mode_e      mode;
    logic       hwi_ack, double_fault;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_sequencer #(.HWI_LEVEL(0)) dut (
        .clk          (clk),
        .rst          (rst),
        .step         (step),
        .jump         (jump),
        .jump_target  (jump_target),
        .swi          (swi),
        .iret         (iret),
        .exc          (exc),
        .hwi_req      (hwi_req),
        .addr         (addr),
        .mode         (mode),
        .hwi_ack      (hwi_ack),
        .double_fault (double_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       st, j, sw, ir, ex, hw, rs;
        logic [3:0] jt;
        logic [5:0] exp_addr;  // after the edge
        logic       exp_ack;   // before the edge
        logic       exp_df;    // after the edge
    } vec_t;

    typedef struct {
        int         idx;
        logic [5:0] exp_addr;
        logic       exp_df;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];

    task automatic add(input logic st, input logic j, input logic [3:0] jt,
                       input logic sw, input logic ir, input logic ex,
                       input logic hw, input logic rs,
                       input logic [5:0] ea, input logic eack, input logic edf);
        vec_t v;
        v.st = st; v.j = j; v.jt = jt; v.sw = sw; v.ir = ir; v.ex = ex;
        v.hw = hw; v.rs = rs; v.exp_addr = ea; v.exp_ack = eack; v.exp_df = edf;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [5:0] act, input logic [5:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic check_state();
        sb_t e;
        logic [1:0] em;
        e  = sb.pop_front();
        em = e.exp_addr[5:4];
        chk("phys_addr", e.idx, addr.phys_addr, e.exp_addr);
        chk("mode", e.idx, {4'b0, mode}, {4'b0, em});
        chk("double_fault", e.idx, {5'b0, double_fault}, {5'b0, e.exp_df});
    endtask

    initial begin
        // ---- stimulus table ----
        // 16 plain steps wrap within the NORMAL region
        for (int i = 1; i <= 16; i++) add(1,0,0,0,0,0,0,0, 6'(i % 16), 0, 0);
        for (int i = 1; i <= 5; i++)  add(1,0,0,0,0,0,0,0, 6'(i), 0, 0);
        // swi at pc=5, swi inside handler ignored, iret back to 6
        add(1,0,0,1,0,0,0,0, 6'h10, 0, 0);
        add(1,0,0,0,0,0,0,0, 6'h11, 0, 0);
        add(1,0,0,1,0,0,0,0, 6'h12, 0, 0);
        add(1,0,0,0,0,0,0,0, 6'h13, 0, 0);
        add(1,0,0,0,1,0,0,0, 6'h06, 0, 0);
        // exc at pc=3, nested exc -> double fault, iret retries pc 3
        add(1,1,3,0,0,0,0,0, 6'h03, 0, 0);
        add(1,0,0,0,0,1,0,0, 6'h20, 0, 0);
        add(1,0,0,0,0,0,0,0, 6'h21, 0, 0);
        add(1,0,0,0,0,1,0,0, 6'h20, 0, 1);
        add(1,0,0,0,1,0,0,0, 6'h03, 0, 1);
        // hwi edge while in SWI handler is deferred until after iret
        add(1,0,0,1,0,0,0,0, 6'h10, 0, 1);
        add(0,0,0,0,0,0,1,0, 6'h10, 0, 1);
        add(1,0,0,0,0,0,0,0, 6'h11, 0, 1);
        add(1,0,0,0,1,0,0,0, 6'h04, 0, 1);
        add(1,0,0,0,0,0,0,0, 6'h30, 1, 1);
        add(1,0,0,0,0,0,0,0, 6'h31, 0, 1);
        add(1,0,0,0,1,0,0,0, 6'h05, 0, 1);
        // jump+exc+pending hwi on one step at pc=7: exc wins, hwi after iret
        add(1,1,7,0,0,0,0,0, 6'h07, 0, 1);
        add(0,0,0,0,0,0,1,0, 6'h07, 0, 1);
        add(1,1,2,0,0,1,0,0, 6'h20, 0, 1);
        add(1,0,0,0,1,0,0,0, 6'h07, 0, 1);
        add(1,0,0,0,0,0,0,0, 6'h30, 1, 1);
        add(1,0,0,0,1,0,0,0, 6'h08, 0, 1);
        // step low holds everything even with jump asserted
        for (int i = 0; i < 10; i++) add(0,1,4'hA,0,0,0,0,0, 6'h08, 0, 1);
        // pending hwi not acked while step low; then enter HWI, reset mid-handler
        add(0,0,0,0,0,0,1,0, 6'h08, 0, 1);
        add(0,0,0,0,0,0,0,0, 6'h08, 0, 1);
        add(1,0,0,0,0,0,0,0, 6'h30, 1, 1);
        add(1,0,0,0,0,0,0,0, 6'h31, 0, 1);
        add(1,0,0,0,0,0,1,1, 6'h00, 0, 0);   // reset, hwi edge in reset cycle
        add(1,0,0,0,0,0,1,0, 6'h01, 0, 0);
        add(1,0,0,0,0,0,0,0, 6'h02, 0, 0);
        // iret in NORMAL acts as exception; then a real double fault
        add(1,0,0,0,1,0,0,0, 6'h20, 0, 0);
        add(1,0,0,0,0,1,0,0, 6'h20, 0, 1);
        add(1,0,0,0,1,0,0,0, 6'h02, 0, 1);
        // hwi taken alongside a jump returns to the jump target
        add(0,0,0,0,0,0,1,0, 6'h02, 0, 1);
        add(1,1,4'hC,0,0,0,0,0, 6'h30, 1, 1);
        add(1,0,0,0,1,0,0,0, 6'h0C, 0, 1);

        // ---- reset ----
        rst = 1; step = 0; jump = 0; jump_target = 0; swi = 0; iret = 0; exc = 0; hwi_req = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_addr", -1, addr.phys_addr, 6'h00);
        chk("reset_mode", -1, {4'b0, mode}, 6'h00);
        chk("reset_df",   -1, {5'b0, double_fault}, 6'h00);
        chk("reset_ack",  -1, {5'b0, hwi_ack}, 6'h00);
        rst = 0;

        // ---- apply table ----
        for (int i = 0; i < vecs.size(); i++) begin
            sb_t e;
            @(negedge clk);
            if (sb.size() != 0) check_state();
            step = vecs[i].st; jump = vecs[i].j; jump_target = vecs[i].jt;
            swi = vecs[i].sw; iret = vecs[i].ir; exc = vecs[i].ex;
            hwi_req = vecs[i].hw; rst = vecs[i].rs;
            #1;
            chk("hwi_ack", i, {5'b0, hwi_ack}, {5'b0, vecs[i].exp_ack});
            e.idx = i; e.exp_addr = vecs[i].exp_addr; e.exp_df = vecs[i].exp_df;
            sb.push_back(e);
        end
        @(negedge clk);
        if (sb.size() != 0) check_state();
        step = 0; rst = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
